// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM state type and sign-extension helper for the
// iterative RV64M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [2:0] {IDLE, PRE, CALC, FIX, DONE} state_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of BITS_PER_CYCLE shift-add (multiply) or restoring-subtract
// (divide) steps; purely combinational.
module muldiv_iter_step
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [2*XLEN-1:0] mcand_in,
  input  logic [XLEN-1:0]   shreg_in,
  output logic [2*XLEN-1:0] acc_out,
  output logic [2*XLEN-1:0] mcand_out,
  output logic [XLEN-1:0]   shreg_out
);

  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   shreg;
  logic [XLEN:0]     trial;

  // Divide: acc[XLEN:0] is the partial remainder, shreg shifts dividend out
  // and quotient in, mcand[XLEN-1:0] holds the divisor.
  always_comb begin
    acc   = acc_in;
    mcand = mcand_in;
    shreg = shreg_in;
    trial = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        trial = {acc[XLEN-1:0], shreg[XLEN-1]};
        shreg = {shreg[XLEN-2:0], 1'b0};
        if (trial >= {1'b0, mcand[XLEN-1:0]}) begin
          trial    = trial - {1'b0, mcand[XLEN-1:0]};
          shreg[0] = 1'b1;
        end
        acc = {{(XLEN-1){1'b0}}, trial};
      end else begin
        if (shreg[0]) acc = acc + mcand;
        mcand = {mcand[2*XLEN-2:0], 1'b0};
        shreg = {1'b0, shreg[XLEN-1:1]};
      end
    end
    acc_out   = acc;
    mcand_out = mcand;
    shreg_out = shreg;
  end

endmodule

// File: rtl/muldiv_iter.sv
// Multi-cycle RV64M multiply/divide unit with valid/ready handshakes;
// divide-by-zero, signed overflow and illegal W ops complete in one cycle.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            is_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [6:0] CNT_FULL = 7'(XLEN / BITS_PER_CYCLE);
  localparam logic [6:0] CNT_WORD = 7'(32 / BITS_PER_CYCLE);

  state_t state, state_n;

  logic [2:0]        op;
  logic              word, neg_q, neg_r;
  logic [2*XLEN-1:0] acc, mcand, acc_nx, mcand_nx;
  logic [XLEN-1:0]   shreg, shreg_nx;
  logic [6:0]        cnt;

  logic              word_en, fast;
  logic [XLEN-1:0]   a_in, b_in, min_n, fast_res;
  logic [63:0]       s1_sx, s2_sx, s1_zx, s2_zx, w_min;

  logic              sgn1, sgn2;
  logic [XLEN-1:0]   abs1, abs2;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, fix_res;
  logic [63:0]       fix_sx;

  assign word_en   = (XLEN == 64) && is_word;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operand extension and single-cycle special-case detection at accept.
  always_comb begin
    s1_sx = sext32(src1[31:0]);
    s2_sx = sext32(src2[31:0]);
    s1_zx = {32'h0, src1[31:0]};
    s2_zx = {32'h0, src2[31:0]};
    w_min = sext32(32'h8000_0000);
    a_in  = src1;
    b_in  = src2;
    if (word_en) begin
      if (funct3 == MD_DIVU || funct3 == MD_REMU) begin
        a_in = s1_zx[XLEN-1:0];
        b_in = s2_zx[XLEN-1:0];
      end else begin
        a_in = s1_sx[XLEN-1:0];
        b_in = s2_sx[XLEN-1:0];
      end
    end
    min_n    = word_en ? w_min[XLEN-1:0] : {1'b1, {(XLEN-1){1'b0}}};
    fast     = 1'b0;
    fast_res = '0;
    if (word_en && (funct3 inside {MD_MULH, MD_MULHSU, MD_MULHU})) begin
      fast = 1'b1;
    end else if (funct3[2] && b_in == '0) begin
      fast     = 1'b1;
      fast_res = funct3[1] ? (word_en ? s1_sx[XLEN-1:0] : src1) : '1;
    end else if ((funct3 == MD_DIV || funct3 == MD_REM) && a_in == min_n && b_in == '1) begin
      fast     = 1'b1;
      fast_res = funct3[1] ? '0 : min_n;
    end
  end

  always_comb begin
    sgn1 = shreg[XLEN-1] && (op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    sgn2 = mcand[XLEN-1] && (op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
    abs1 = sgn1 ? -shreg : shreg;
    abs2 = sgn2 ? -mcand[XLEN-1:0] : mcand[XLEN-1:0];
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -shreg : shreg;
    rmd  = neg_r ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    if (op[2])              fix_res = op[1] ? rmd : quo;
    else if (op == MD_MUL)  fix_res = prod[XLEN-1:0];
    else                    fix_res = prod[2*XLEN-1:XLEN];
    fix_sx = sext32(fix_res[31:0]);
    if (word) fix_res = fix_sx[XLEN-1:0];
  end

  muldiv_iter_step #(
    .XLEN          (XLEN),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .is_div   (op[2]),
    .acc_in   (acc),
    .mcand_in (mcand),
    .shreg_in (shreg),
    .acc_out  (acc_nx),
    .mcand_out(mcand_nx),
    .shreg_out(shreg_nx)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (in_valid) state_n = fast ? DONE : PRE;
        PRE:     state_n = CALC;
        CALC:    if (cnt == 7'd1) state_n = FIX;
        FIX:     state_n = DONE;
        DONE:    if (out_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // W divides pre-shift the 32-bit dividend into the upper half so that
  // 32 iterations leave the quotient in shreg[31:0].
  always_ff @(posedge clock) begin
    if (reset) begin
      op     <= '0;
      word   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      shreg  <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (!flush) begin
      unique case (state)
        IDLE: if (in_valid) begin
          op    <= funct3;
          word  <= word_en;
          shreg <= a_in;
          mcand <= {{XLEN{1'b0}}, b_in};
          if (fast) result <= fast_res;
        end
        PRE: begin
          neg_q <= sgn1 ^ sgn2;
          neg_r <= sgn1;
          acc   <= '0;
          mcand <= {{XLEN{1'b0}}, abs2};
          shreg <= (op[2] && word) ? abs1 << (XLEN / 2) : abs1;
          cnt   <= word ? CNT_WORD : CNT_FULL;
        end
        CALC: begin
          acc   <= acc_nx;
          mcand <= mcand_nx;
          shreg <= shreg_nx;
          cnt   <= cnt - 7'd1;
        end
        FIX:     result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter (XLEN=64, one bit per cycle) using a
// queue of expected results filled at issue and drained at completion.
module tb_muldiv_iter;
  import muldiv_pkg::*;

  typedef struct packed {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic [7:0]  lat;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = '0;
  logic        is_word = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;

  logic [63:0] sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  muldiv_iter #(
    .XLEN          (64),
    .BITS_PER_CYCLE(1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .funct3   (funct3),
    .is_word  (is_word),
    .src1     (src1),
    .src2     (src2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  always #5 clock = ~clock;

  task automatic send(input logic [2:0] f3, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp);
    @(negedge clock);
    funct3 = f3; is_word = w; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    sb.push_back(exp);
  endtask

  // cyc counts edges from the accept edge (inclusive); 0 means timeout.
  task automatic wait_valid(output int cyc, output int busy_ready);
    cyc = 1;
    busy_ready = 0;
    while (!out_valid && cyc < 200) begin
      if (in_ready) busy_ready++;
      @(posedge clock); #1;
      cyc++;
    end
    if (!out_valid) cyc = 0;
  endtask

  task automatic take_result;
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (result !== 64'h0) begin n_fail++; $display("FAIL reset result: got %h expected 0", result); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_arith;
    vec_t t [14];
    int cyc, busy;
    logic [63:0] exp;
    t[0]  = '{MD_DIV,    1'b0, -64'sd7, 64'd2, -64'sd3, 8'd67};
    t[1]  = '{MD_REM,    1'b0, -64'sd7, 64'd2, -64'sd1, 8'd67};
    t[2]  = '{MD_MULH,   1'b0, -64'sd1, -64'sd1, 64'h0, 8'd67};
    t[3]  = '{MD_MULHU,  1'b0, -64'sd1, -64'sd1, 64'hFFFF_FFFF_FFFF_FFFE, 8'd67};
    t[4]  = '{MD_MULHSU, 1'b0, -64'sd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'd67};
    t[5]  = '{MD_MUL,    1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 8'd35};
    t[6]  = '{MD_MUL,    1'b0, 64'h1_2345_6789, 64'h1000, 64'h1234_5678_9000, 8'd67};
    t[7]  = '{MD_MUL,    1'b0, -64'sd3, 64'd5, -64'sd15, 8'd67};
    t[8]  = '{MD_DIV,    1'b1, -64'sd100, 64'd7, -64'sd14, 8'd35};
    t[9]  = '{MD_DIVU,   1'b1, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 8'd35};
    t[10] = '{MD_REMU,   1'b0, 64'd1000, 64'd7, 64'd6, 8'd67};
    t[11] = '{MD_REM,    1'b1, 64'h5_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'd35};
    t[12] = '{MD_DIVU,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 8'd67};
    t[13] = '{MD_MULH,   1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'h4000_0000_0000_0000, 8'd67};
    for (int i = 0; i < 14; i++) begin
      send(t[i].f3, t[i].w, t[i].a, t[i].b, t[i].exp);
      wait_valid(cyc, busy);
      exp = sb.pop_front();
      n_checks++;
      if (cyc !== int'(t[i].lat)) begin
        n_fail++; $display("FAIL arith[%0d] latency: got %0d expected %0d", i, cyc, t[i].lat);
      end
      n_checks++;
      if (result !== exp) begin
        n_fail++; $display("FAIL arith[%0d] result: got %h expected %h", i, result, exp);
      end
      n_checks++;
      if (busy !== 0) begin
        n_fail++; $display("FAIL arith[%0d] in_ready while busy: got %0d cycles expected 0", i, busy);
      end
      take_result();
    end
  endtask

  task automatic test_special;
    vec_t t [8];
    int cyc, busy;
    logic [63:0] exp;
    t[0] = '{MD_DIVU, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'd1};
    t[1] = '{MD_REM,  1'b1, 64'h1_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 8'd1};
    t[2] = '{MD_DIV,  1'b0, 64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, 8'd1};
    t[3] = '{MD_REM,  1'b0, 64'h8000_0000_0000_0000, -64'sd1, 64'h0, 8'd1};
    t[4] = '{MD_DIV,  1'b1, 64'h8000_0000, -64'sd1, 64'hFFFF_FFFF_8000_0000, 8'd1};
    t[5] = '{MD_MULHU, 1'b1, 64'd5, 64'd7, 64'h0, 8'd1};
    t[6] = '{MD_REMU, 1'b1, 64'hFFFF_FFFF_8000_0001, 64'hAB_0000_0000, 64'hFFFF_FFFF_8000_0001, 8'd1};
    t[7] = '{MD_DIV,  1'b0, -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'd1};
    for (int i = 0; i < 8; i++) begin
      send(t[i].f3, t[i].w, t[i].a, t[i].b, t[i].exp);
      wait_valid(cyc, busy);
      exp = sb.pop_front();
      n_checks++;
      if (cyc !== int'(t[i].lat)) begin
        n_fail++; $display("FAIL special[%0d] latency: got %0d expected %0d", i, cyc, t[i].lat);
      end
      n_checks++;
      if (result !== exp) begin
        n_fail++; $display("FAIL special[%0d] result: got %h expected %h", i, result, exp);
      end
      take_result();
    end
  endtask

  task automatic test_back_to_back;
    int cyc, busy, bad;
    logic [63:0] exp;
    send(MD_DIV, 1'b0, -64'sd7, 64'd2, -64'sd3);
    wait_valid(cyc, busy);
    exp = sb.pop_front();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (result !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL hold stable: got %0d bad cycles expected 0", bad); end
    n_checks++;
    if (result !== exp) begin n_fail++; $display("FAIL hold result: got %h expected %h", result, exp); end
    take_result();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL handshake idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    send(MD_MUL, 1'b0, 64'd6, 64'd7, 64'd42);
    wait_valid(cyc, busy);
    exp = sb.pop_front();
    n_checks++;
    if (cyc !== 67) begin n_fail++; $display("FAIL b2b latency: got %0d expected 67", cyc); end
    n_checks++;
    if (result !== exp) begin n_fail++; $display("FAIL b2b result: got %h expected %h", result, exp); end
    take_result();
  endtask

  task automatic test_flush;
    int seen;
    logic [63:0] discard;
    send(MD_DIV, 1'b0, 64'd1000, 64'd7, 64'd142);
    discard = sb.pop_front();
    repeat (20) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush idle: got in_ready=%b out_valid=%b expected 1/0 (dropped %h)",
                         in_ready, out_valid, discard);
    end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clock); #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL flush no result: got %0d valid cycles expected 0", seen); end
    @(negedge clock);
    funct3 = MD_DIVU; is_word = 1'b0; src1 = 64'd3; src2 = 64'd0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush blocks accept: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, busy;
    logic [63:0] exp;
    send(MD_DIVU, 1'b0, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid(cyc, busy);
    exp = sb.pop_front();
    n_checks++;
    if (result !== exp || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre-reset done: got %h valid=%b expected %h valid=1", result, out_valid, exp);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset-in-done out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (result !== 64'h0) begin n_fail++; $display("FAIL reset-in-done result: got %h expected 0", result); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset-in-done in_ready: got %b expected 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_special();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
